// File: rtl/iter_shift_unit.sv
// Multi-cycle shift/rotate engine: accepts an operand and count under a
// start/done handshake, then shifts up to STEP bit positions per clock.
module iter_shift_unit #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input  logic               clock,
    input  logic               clear,
    input  logic               start,
    input  logic [2:0]         op,
    input  logic [WIDTH-1:0]   data_in,
    input  logic [AMT_W-1:0]   amount,
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    localparam logic [2:0]   OP_SHR  = 3'b000;
    localparam logic [2:0]   OP_SHRA = 3'b001;
    localparam logic [2:0]   OP_SHL  = 3'b010;
    localparam logic [2:0]   OP_ROR  = 3'b011;
    localparam logic [2:0]   OP_ROL  = 3'b100;
    localparam logic [AMT_W:0] STEP_C = (AMT_W+1)'(STEP);

    state_t              state_r;
    state_t              state_s;
    logic [WIDTH-1:0]    result_r;
    logic [WIDTH-1:0]    result_s;
    logic [AMT_W-1:0]    count_r;
    logic [AMT_W-1:0]    count_s;
    logic [2:0]          op_r;
    logic [2:0]          op_s;
    logic                sign_r;
    logic                sign_s;
    logic                ready_r;
    logic                busy_r;
    logic                done_r;
    logic [AMT_W:0]      count_ext_s;
    logic [AMT_W:0]      k_s;

    // Shift val by k (0 < k < WIDTH) according to op; SHRA fills with the
    // sign captured at accept time, rotates keep every bit.
    function automatic logic [WIDTH-1:0] shift_step(
        input logic [2:0]       op_f,
        input logic [WIDTH-1:0] val,
        input logic             sign,
        input logic [AMT_W:0]   k
    );
        logic [WIDTH-1:0] res;
        case (op_f)
            OP_SHR:  res = val >> k;
            OP_SHRA: res = WIDTH'($signed({sign, val}) >>> k);
            OP_SHL:  res = val << k;
            OP_ROR:  res = WIDTH'({val, val} >> k);
            OP_ROL:  res = WIDTH'(({val, val} << k) >> WIDTH);
            default: res = val;
        endcase
        return res;
    endfunction

    function automatic logic is_pass(input logic [2:0] op_f);
        return (op_f >= 3'b101);
    endfunction

    // Step size for this cycle: the remaining count, capped at STEP.
    always_comb begin
        count_ext_s = {1'b0, count_r};
        if (count_ext_s < STEP_C) begin
            k_s = count_ext_s;
        end else begin
            k_s = STEP_C;
        end
    end

    // Next-state and datapath update for the handshake/iteration FSM.
    always_comb begin
        state_s  = state_r;
        result_s = result_r;
        count_s  = count_r;
        op_s     = op_r;
        sign_s   = sign_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    op_s     = op;
                    result_s = data_in;
                    count_s  = amount;
                    sign_s   = data_in[WIDTH-1];
                    if (is_pass(op) || (amount == {AMT_W{1'b0}})) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_SHIFT;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                result_s = shift_step(op_r, result_r, sign_r, k_s);
                count_s  = count_r - k_s[AMT_W-1:0];
                if (count_s == {AMT_W{1'b0}}) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            default: begin
                state_s  = ST_IDLE;
                result_s = {WIDTH{1'b0}};
                count_s  = {AMT_W{1'b0}};
            end
        endcase
    end

    // State, datapath and registered status flags; clear wipes everything.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_r  <= ST_IDLE;
            result_r <= {WIDTH{1'b0}};
            count_r  <= {AMT_W{1'b0}};
            op_r     <= 3'b000;
            sign_r   <= 1'b0;
            ready_r  <= 1'b1;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            result_r <= result_s;
            count_r  <= count_s;
            op_r     <= op_s;
            sign_r   <= sign_s;
            ready_r  <= (state_s != ST_SHIFT);
            busy_r   <= (state_s == ST_SHIFT);
            done_r   <= (state_s == ST_DONE);
        end
    end

    assign ready  = ready_r;
    assign busy   = busy_r;
    assign done   = done_r;
    assign result = result_r;

endmodule

// File: doc/iter_shift_unit.md
# iter_shift_unit

Parametrised multi-cycle shift/rotate engine for the Mini-SRC datapath. It takes an operand and shift amount under a start/done handshake and iterates STEP bit positions per clock. It supports logical right, arithmetic right, left, rotate-right and rotate-left. The ALU hands shift-class opcodes to this unit and latches `result` into Z when `done` pulses.

## Interface
- `WIDTH`, 32, operand/result width in bits (≥ 4, power of 2).
- `STEP`, 1, bit positions shifted per iteration cycle (power of 2, 1 ≤ STEP ≤ WIDTH).
- `AMT_W`, $clog2(WIDTH), width of the shift-amount port.
- `clock`  in  1  system clock, all state updates on the rising edge.
- `clear`  in  1  reset, asynchronous and active-high.
- `start`  in  1  request; sampled only when `ready`=1.
- `op`  in  3  000 SHR, 001 SHRA, 010 SHL, 011 ROR, 100 ROL, 101–111 pass-through.
- `data_in`  in  WIDTH  operand, captured on the accepting edge.
- `amount`  in  AMT_W  shift count (0..WIDTH-1), captured on the accepting edge.
- `ready`  out  1  unit accepts `start` this cycle (state IDLE or DONE).
- `busy`  out  1  iteration in progress (state SHIFT).
- `done`  out  1  one-cycle pulse; `result` is final.
- `result`  out  WIDTH  working/final register; holds last final value until the next accept.

## Operation
- States: IDLE, SHIFT, DONE. Reset state is IDLE. Reset output values: `ready`=1, `busy`=0, `done`=0, `result`=0.
- Accept (`start`=1 and `ready`=1):
  - latch op; `result` ← `data_in`; `count` ← `amount`.
  - Pass-through op or `amount`=0: next state DONE, with `result`=`data_in`.
  - Otherwise: next state SHIFT.
- SHIFT, each edge:
  - k = min(STEP, count). Shift `result` by k per op; `count` ← count − k.
  - When the new count is 0: next state DONE. Otherwise stay in SHIFT.
- Fill rules:
  - SHR shifts in zeros at the MSB.
  - SHRA replicates the operand's original sign bit (bit WIDTH-1).
  - SHL shifts in zeros at the LSB.
  - ROR and ROL wrap bits around; no bits are lost.
- DONE lasts exactly one cycle:
  - `start`=1: accept, so back-to-back operations need no idle gap.
  - Otherwise: IDLE.
- `start` in SHIFT is ignored. It is not queued, and `data_in`/`amount` are not sampled.
- `result` is not modified in IDLE or DONE except by an accept.
- `amount` is unsigned modulo 2^AMT_W, so values ≥ WIDTH cannot occur. No overflow or error flag exists.
- `clear` asserted at any time, including mid-SHIFT:
  - immediately forces IDLE, `result`=0, `count`=0, `done`=0.
  - the in-flight operation is discarded.

## Timing
- Accepting edge E. N = ceil(amount/STEP), with N = 0 for pass-through or amount 0.
- `busy`=1 for the N cycles after edge E.
- `done`=1 for exactly the one cycle after edge E+N.
- Start-to-done latency is N+1 edges counted from E (1 edge minimum).
- `result` in the SHIFT state shows partial values and is not valid. Consumers sample it only with `done`=1, or later while in IDLE.
- Outputs are registered state decodes:
  - `ready` = IDLE|DONE.
  - `busy` = SHIFT.
  - `done` = DONE.
- There is no combinational path from inputs to outputs.

## Test plan
- **Basic SHR, timing.** WIDTH=32, STEP=1: SHR 0x00000045 by 3.
  - Expect `busy` high for 3 cycles, then `done` for 1 cycle with `result`=0x00000008.
  - Then IDLE, with `result` held.
- **Sign fill and rotate.** STEP=1:
  - SHRA 0x80000034 by 4 → 0xF8000003.
  - ROR 0x112B0000 by 16 → 0x0000112B after 16 busy cycles.
  - ROL 0x80000001 by 1 → 0x00000003.
- **Multi-bit step.** STEP=4 instance: SHL 0x00000034 by 6 → 2 busy cycles (shifts of 4, then 2), then `done` with 0x00000D00.
- **Zero amount and pass-through.**
  - amount=0 SHR 0x12345678 → no busy cycle; `done` in the cycle after the accept; `result`=0x12345678.
  - op=111 behaves the same.
- **Handshake edges.**
  - `start` pulsed mid-SHIFT with a different operand → ignored; the original result completes.
  - `start` held during DONE → new op accepted, with no IDLE cycle between.
- **Reset mid-operation.**
  - `clear` asserted asynchronously, between edges, in the 2nd busy cycle of SHR 0xFFFFFFFF by 8 → `result`=0, `busy`=0, `ready`=1 before the next edge.
  - No `done` pulse follows.
